dac_sample_scheduler: RTL and testbench

Sample-rate controller in front of `sigma_delta_dac`. It produces a one-cycle sample tick every `SAMPLE_PERIOD` clocks. On each tick it pulls one code from the selected requester, either the CPU audio path or the synth, over a ready/valid handshake. It holds that code on `dac_code` until the next tick. On a source change or mute it ramps the output to midscale before switching, so the DAC never sees a step; stalled sources are counted as underruns.

---
 rtl/dac_sample_scheduler.sv | 121 ++++++++++++
 tb/tb_dac_sample_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// Sample-rate controller for sigma_delta_dac: pulls one code per sample tick from the
// selected source and ramps to midscale before any source change or mute.
module dac_sample_scheduler #(
  parameter int CODE_WIDTH    = 10,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int RAMP_STEP     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            src_sel,
  input  logic [CODE_WIDTH-1:0] cpu_code,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [CODE_WIDTH-1:0] synth_code,
  input  logic                  synth_valid,
  output logic                  synth_ready,
  output logic [CODE_WIDTH-1:0] dac_code,
  output logic                  sample_tick,
  output logic [1:0]            active_src,
  output logic [15:0]           underrun_count,
  input  logic                  underrun_clr
);

  localparam logic [1:0] ST_MUTED = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CODE_WIDTH-1:0] MID      = {1'b1, {(CODE_WIDTH-1){1'b0}}};
  localparam logic [CODE_WIDTH:0]   MID_W    = {1'b0, MID};
  localparam logic [CODE_WIDTH:0]   STEP_W   = (CODE_WIDTH+1)'(RAMP_STEP);
  localparam logic [CODE_WIDTH:0]   UPPER_W  = MID_W + STEP_W;
  localparam logic [CODE_WIDTH:0]   LOWER_W  = MID_W - STEP_W;
  localparam logic [15:0]           CNT_LAST = 16'(SAMPLE_PERIOD - 1);

  logic [15:0]           cnt;
  logic [1:0]            state;
  logic                  sel_match;
  logic                  sel_valid;
  logic [CODE_WIDTH-1:0] sel_code;
  logic [CODE_WIDTH:0]   code_w;
  logic                  in_play_tick;
  logic                  underrun_inc;

  assign sample_tick = (cnt == CNT_LAST);

  // Source mux for whichever requester currently owns the output.
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = MID;
    if (active_src == 2'd1) begin
      sel_valid = cpu_valid;
      sel_code  = cpu_code;
    end else if (active_src == 2'd2) begin
      sel_valid = synth_valid;
      sel_code  = synth_code;
    end
  end

  assign sel_match    = (src_sel == active_src);
  assign in_play_tick = sample_tick && (state == ST_PLAY);
  assign code_w       = {1'b0, dac_code};
  assign cpu_ready    = in_play_tick && (active_src == 2'd1) && (src_sel == 2'd1) && cpu_valid;
  assign synth_ready  = in_play_tick && (active_src == 2'd2) && (src_sel == 2'd2) && synth_valid;
  assign underrun_inc = in_play_tick && sel_match && !sel_valid;

  // Period counter and MUTED/PLAY/DRAIN sequencing; everything moves only on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      state      <= ST_MUTED;
      dac_code   <= MID;
      active_src <= 2'd0;
    end else begin
      cnt <= sample_tick ? 16'd0 : cnt + 16'd1;
      if (sample_tick) begin
        case (state)
          ST_MUTED: begin
            if (src_sel == 2'd1 || src_sel == 2'd2) begin
              active_src <= src_sel;
              state      <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (!sel_match) begin
              state <= ST_DRAIN;
            end else if (sel_valid) begin
              dac_code <= sel_code;
            end
          end
          ST_DRAIN: begin
            // Ramp toward midscale; the last partial step snaps to MID.
            if (code_w > UPPER_W) begin
              dac_code <= CODE_WIDTH'(code_w - STEP_W);
            end else if (code_w < LOWER_W) begin
              dac_code <= CODE_WIDTH'(code_w + STEP_W);
            end else begin
              dac_code   <= MID;
              active_src <= 2'd0;
              state      <= ST_MUTED;
            end
          end
          default: begin
            dac_code   <= MID;
            active_src <= 2'd0;
            state      <= ST_MUTED;
          end
        endcase
      end
    end
  end

  // Clear takes priority over a coincident underrun increment.
  always_ff @(posedge clk) begin
    if (rst || underrun_clr) begin
      underrun_count <= '0;
    end else if (underrun_inc && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with a queue of expected DAC codes.
module tb_dac_sample_scheduler;

  localparam int CW = 10;
  localparam int SP = 4;
  localparam int RS = 64;

  logic          clk;
  logic          rst;
  logic [1:0]    src_sel;
  logic [CW-1:0] cpu_code;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [CW-1:0] synth_code;
  logic          synth_valid;
  logic          synth_ready;
  logic [CW-1:0] dac_code;
  logic          sample_tick;
  logic [1:0]    active_src;
  logic [15:0]   underrun_count;
  logic          underrun_clr;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_q[$];

  dac_sample_scheduler #(
    .CODE_WIDTH(CW),
    .SAMPLE_PERIOD(SP),
    .RAMP_STEP(RS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_sel(src_sel),
    .cpu_code(cpu_code),
    .cpu_valid(cpu_valid),
    .cpu_ready(cpu_ready),
    .synth_code(synth_code),
    .synth_valid(synth_valid),
    .synth_ready(synth_ready),
    .dac_code(dac_code),
    .sample_tick(sample_tick),
    .active_src(active_src),
    .underrun_count(underrun_count),
    .underrun_clr(underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive a sample on one source and record it as the next expected DAC code.
  task automatic applyStimulus(input int source, input logic [CW-1:0] code);
    if (source == 1) begin
      cpu_code  = code;
      cpu_valid = 1'b1;
    end else begin
      synth_code  = code;
      synth_valid = 1'b1;
    end
    exp_q.push_back(code);
  endtask

  task automatic checkScoreboard(input string tag);
    logic [CW-1:0] exp_code;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp_code = exp_q.pop_front();
      checkOutput(tag, 32'(dac_code), 32'(exp_code));
    end
  endtask

  // Advance to the next negedge where sample_tick is high, with a bounded wait.
  task automatic waitTick();
    logic found;
    found = 1'b0;
    for (int n = 0; n < 2 * SP; n++) begin
      @(negedge clk);
      if (sample_tick) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("tick_wait", 32'(found), 32'd1);
  endtask

  task automatic checkReadies(input string tag, input logic exp_cpu, input logic exp_synth);
    checkOutput({tag, "_cpu_ready"}, 32'(cpu_ready), 32'(exp_cpu));
    checkOutput({tag, "_synth_ready"}, 32'(synth_ready), 32'(exp_synth));
  endtask

  initial begin
    rst          = 1'b1;
    src_sel      = 2'd0;
    cpu_code     = '0;
    cpu_valid    = 1'b0;
    synth_code   = '0;
    synth_valid  = 1'b0;
    underrun_clr = 1'b0;
    $display("[TB] start");

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_dac", 32'(dac_code), 32'd512);
    checkOutput("reset_active", 32'(active_src), 32'd0);
    checkOutput("reset_underrun", 32'(underrun_count), 32'd0);
    checkOutput("reset_tick", 32'(sample_tick), 32'd0);
    checkReadies("reset", 1'b0, 1'b0);

    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checkOutput("idle_tick", 32'(sample_tick), ((i % 4) == 3) ? 32'd1 : 32'd0);
      checkOutput("idle_dac", 32'(dac_code), 32'd512);
      checkReadies("idle", 1'b0, 1'b0);
    end

    $display("[TB] cpu play");
    src_sel = 2'd1;
    applyStimulus(1, 10'd100);
    waitTick();
    checkReadies("muted_to_play", 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("play_active", 32'(active_src), 32'd1);
    checkOutput("play_dac_mid", 32'(dac_code), 32'd512);
    waitTick();
    checkReadies("accept_100", 1'b1, 1'b0);
    @(negedge clk);
    checkScoreboard("dac_100");
    applyStimulus(1, 10'd200);
    waitTick();
    checkReadies("accept_200", 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("between_ticks_ready", 32'(cpu_ready), 32'd0);
    checkScoreboard("dac_200");
    applyStimulus(1, 10'd300);
    waitTick();
    checkReadies("accept_300", 1'b1, 1'b0);
    @(negedge clk);
    checkScoreboard("dac_300");

    $display("[TB] underrun");
    cpu_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      waitTick();
      checkReadies("underrun", 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("underrun_dac_hold", 32'(dac_code), 32'd300);
      checkOutput("underrun_count", 32'(underrun_count), 32'(i));
    end
    underrun_clr = 1'b1;
    waitTick();
    @(negedge clk);
    checkOutput("underrun_clear_wins", 32'(underrun_count), 32'd0);
    underrun_clr = 1'b0;

    $display("[TB] drain ramp");
    applyStimulus(1, 10'd900);
    waitTick();
    checkReadies("accept_900", 1'b1, 1'b0);
    @(negedge clk);
    checkScoreboard("dac_900");
    src_sel     = 2'd2;
    synth_code  = 10'd333;
    synth_valid = 1'b1;
    waitTick();
    checkReadies("play_to_drain", 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drain_entry_dac", 32'(dac_code), 32'd900);
    checkOutput("drain_entry_active", 32'(active_src), 32'd1);
    exp_q.push_back(10'd836);
    exp_q.push_back(10'd772);
    exp_q.push_back(10'd708);
    exp_q.push_back(10'd644);
    exp_q.push_back(10'd580);
    exp_q.push_back(10'd516);
    exp_q.push_back(10'd512);
    for (int k = 0; k < 7; k++) begin
      if (k == 1) src_sel = 2'd1;
      if (k == 5) src_sel = 2'd2;
      waitTick();
      checkReadies("drain", 1'b0, 1'b0);
      @(negedge clk);
      checkScoreboard("drain_step");
    end
    checkOutput("drain_done_active", 32'(active_src), 32'd0);
    waitTick();
    checkReadies("rearm_tick", 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rearm_active", 32'(active_src), 32'd2);
    checkOutput("rearm_dac", 32'(dac_code), 32'd512);
    applyStimulus(2, 10'd333);
    waitTick();
    checkReadies("accept_333", 1'b0, 1'b1);
    @(negedge clk);
    checkScoreboard("dac_333");

    $display("[TB] reset during drain");
    applyStimulus(2, 10'd900);
    waitTick();
    checkReadies("accept_synth_900", 1'b0, 1'b1);
    @(negedge clk);
    checkScoreboard("dac_synth_900");
    src_sel = 2'd0;
    waitTick();
    @(negedge clk);
    checkOutput("drain2_entry", 32'(dac_code), 32'd900);
    exp_q.push_back(10'd836);
    exp_q.push_back(10'd772);
    exp_q.push_back(10'd708);
    for (int k = 0; k < 3; k++) begin
      waitTick();
      @(negedge clk);
      checkScoreboard("drain2_step");
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_drain_dac", 32'(dac_code), 32'd512);
    checkOutput("rst_drain_active", 32'(active_src), 32'd0);
    checkOutput("rst_drain_tick", 32'(sample_tick), 32'd0);
    rst         = 1'b0;
    src_sel     = 2'd3;
    cpu_valid   = 1'b1;
    synth_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput("rst_drain_cnt_restart", 32'(sample_tick), (i == 3) ? 32'd1 : 32'd0);
    end
    checkReadies("sel3_tick", 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sel3_active", 32'(active_src), 32'd0);
    checkOutput("sel3_dac", 32'(dac_code), 32'd512);
    waitTick();
    checkReadies("sel3_tick2", 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sel3_active2", 32'(active_src), 32'd0);

    $display("[TB] saturation");
    force dut.underrun_count = 16'hFFFD;
    #1;
    release dut.underrun_count;
    src_sel   = 2'd1;
    cpu_valid = 1'b0;
    waitTick();
    @(negedge clk);
    checkOutput("sat_active", 32'(active_src), 32'd1);
    checkOutput("sat_preload", 32'(underrun_count), 32'hFFFD);
    for (int i = 1; i <= 3; i++) begin
      waitTick();
      @(negedge clk);
      checkOutput("sat_count", 32'(underrun_count), (i == 1) ? 32'hFFFE : 32'hFFFF);
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    checkOutput("clear_off_tick", 32'(underrun_count), 32'd0);
    underrun_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
